// File: rtl/cbfp_min_accum.sv
// Block-exponent detector for the CBFP stages: per-beat min-tree over each channel's
// leading-zero counts, then a running minimum across a configurable block of beats.
module cbfp_min_accum #(
  parameter int LZC_WIDTH = 5,
  parameter int LANES     = 8,
  parameter int CH        = 2,
  parameter int MAX_BEATS = 64,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           in_valid,
  input  logic [CH*LANES*LZC_WIDTH-1:0]  in_re,
  input  logic [CH*LANES*LZC_WIDTH-1:0]  in_im,
  input  logic [CNT_W-1:0]               blk_len,
  input  logic                           flush,
  output logic                           out_valid,
  output logic [CH*LZC_WIDTH-1:0]        out_min,
  output logic [LZC_WIDTH-1:0]           out_min_all,
  output logic                           busy
);

  function automatic logic [LZC_WIDTH-1:0] min2(input logic [LZC_WIDTH-1:0] a,
                                                input logic [LZC_WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [LZC_WIDTH-1:0]    w_beat_min [CH];
  logic                    r_s1_valid;
  logic [LZC_WIDTH-1:0]    r_s1_min [CH];
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_len;
  logic [LZC_WIDTH-1:0]    r_acc [CH];
  logic                    r_out_valid;
  logic [CH*LZC_WIDTH-1:0] r_out_min;
  logic [LZC_WIDTH-1:0]    r_out_all;

  logic                    w_first;
  logic                    w_last;
  logic [CNT_W-1:0]        w_len_in;
  logic [CNT_W-1:0]        w_len;
  logic [LZC_WIDTH-1:0]    w_merge [CH];
  logic [CH*LZC_WIDTH-1:0] w_merge_pk;
  logic [LZC_WIDTH-1:0]    w_merge_all;

  // Per-channel minimum over all real and imaginary lanes of the incoming beat
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      w_beat_min[c] = {LZC_WIDTH{1'b1}};
      for (int l = 0; l < LANES; l++) begin
        w_beat_min[c] = min2(w_beat_min[c], in_re[(c*LANES+l)*LZC_WIDTH +: LZC_WIDTH]);
        w_beat_min[c] = min2(w_beat_min[c], in_im[(c*LANES+l)*LZC_WIDTH +: LZC_WIDTH]);
      end
    end
  end

  // Block-length sanitising, last-beat detection and merge with the running minimum
  always_comb begin
    w_first = (r_cnt == {CNT_W{1'b0}});
    if (blk_len == {CNT_W{1'b0}}) begin
      w_len_in = CNT_W'(1);
    end else if (blk_len > CNT_W'(MAX_BEATS)) begin
      w_len_in = CNT_W'(MAX_BEATS);
    end else begin
      w_len_in = blk_len;
    end
    if (w_first) begin
      w_len = w_len_in;
    end else begin
      w_len = r_len;
    end
    w_last      = (r_cnt == w_len - CNT_W'(1));
    w_merge_pk  = {(CH*LZC_WIDTH){1'b0}};
    w_merge_all = {LZC_WIDTH{1'b1}};
    for (int c = 0; c < CH; c++) begin
      // The first beat of a block overwrites so nothing from the previous block survives
      if (w_first) begin
        w_merge[c] = r_s1_min[c];
      end else begin
        w_merge[c] = min2(r_acc[c], r_s1_min[c]);
      end
      w_merge_pk[c*LZC_WIDTH +: LZC_WIDTH] = w_merge[c];
      w_merge_all = min2(w_merge_all, w_merge[c]);
    end
  end

  // Stage-1 capture and stage-2 accumulation; flush overrides any stage-2 update
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid  <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_len       <= CNT_W'(1);
      r_out_valid <= 1'b0;
      r_out_min   <= {(CH*LZC_WIDTH){1'b0}};
      r_out_all   <= {LZC_WIDTH{1'b0}};
      for (int c = 0; c < CH; c++) begin
        r_s1_min[c] <= {LZC_WIDTH{1'b1}};
        r_acc[c]    <= {LZC_WIDTH{1'b1}};
      end
    end else begin
      r_s1_valid  <= in_valid & ~flush;
      r_out_valid <= 1'b0;
      if (in_valid) begin
        for (int c = 0; c < CH; c++) begin
          r_s1_min[c] <= w_beat_min[c];
        end
      end
      if (flush) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (r_s1_valid) begin
        for (int c = 0; c < CH; c++) begin
          r_acc[c] <= w_merge[c];
        end
        if (w_first) begin
          r_len <= w_len_in;
        end
        if (w_last) begin
          r_cnt       <= {CNT_W{1'b0}};
          r_out_min   <= w_merge_pk;
          r_out_all   <= w_merge_all;
          r_out_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_min     = r_out_min;
  assign out_min_all = r_out_all;
  assign busy        = r_s1_valid | (r_cnt != {CNT_W{1'b0}});

endmodule

// File: tb/tb_cbfp_min_accum.sv
// Scoreboard bench for cbfp_min_accum: a behavioural model predicts each block result
// and the cycle it must appear; a negedge monitor compares every cycle.
module tb_cbfp_min_accum;
  localparam int LZ = 5, LANES = 8, CH = 2, MAXB = 64, CW = 7;
  localparam int VW = CH*LANES*LZ;

  logic          clk = 1'b0, rstn = 1'b1, in_valid = 1'b0, flush = 1'b0;
  logic [VW-1:0] in_re = '0, in_im = '0;
  logic [CW-1:0] blk_len = '0;
  logic          out_valid, busy;
  logic [CH*LZ-1:0] out_min;
  logic [LZ-1:0]    out_min_all;

  cbfp_min_accum #(.LZC_WIDTH(LZ), .LANES(LANES), .CH(CH), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .blk_len(blk_len), .flush(flush), .out_valid(out_valid), .out_min(out_min),
    .out_min_all(out_min_all), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    int               due;
    logic [CH*LZ-1:0] mins;
    logic [LZ-1:0]    all;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0, n_checks = 0, n_errors = 0;
  logic [CH*LZ-1:0] hold_min = '0;
  logic [LZ-1:0]    hold_all = '0;
  int            m_cnt = 0, m_len = 1;
  logic [LZ-1:0] m_acc [CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Monitor: pulse timing and held output values, every cycle out of reset
  always @(negedge clk) begin
    bit   exp_v;
    exp_t e;
    if (rstn) begin
      while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      check_eq("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
      if (exp_v) begin
        e = sb.pop_front();
        hold_min = e.mins;
        hold_all = e.all;
      end
      check_eq("out_min", {54'd0, out_min}, {54'd0, hold_min});
      check_eq("out_min_all", {59'd0, out_min_all}, {59'd0, hold_all});
    end
  end

  function automatic int eff_len(input int b);
    if (b == 0) return 1;
    if (b > MAXB) return MAXB;
    return b;
  endfunction

  task automatic model_beat(input logic [VW-1:0] re, input logic [VW-1:0] im);
    logic [LZ-1:0] bm, v;
    exp_t e;
    if (m_cnt == 0) m_len = eff_len(int'(blk_len));
    for (int c = 0; c < CH; c++) begin
      bm = 5'd31;
      for (int l = 0; l < LANES; l++) begin
        v = re[(c*LANES+l)*LZ +: LZ]; if (v < bm) bm = v;
        v = im[(c*LANES+l)*LZ +: LZ]; if (v < bm) bm = v;
      end
      if (m_cnt == 0 || bm < m_acc[c]) m_acc[c] = bm;
    end
    m_cnt++;
    if (m_cnt == m_len) begin
      e.due = cyc + 2;
      e.all = 5'd31;
      for (int c = 0; c < CH; c++) begin
        e.mins[c*LZ +: LZ] = m_acc[c];
        if (m_acc[c] < e.all) e.all = m_acc[c];
      end
      sb.push_back(e);
      m_cnt = 0;
    end
  endtask

  task automatic drive_beat(input logic [VW-1:0] re, input logic [VW-1:0] im);
    @(posedge clk); #2;
    in_valid = 1'b1; flush = 1'b0; in_re = re; in_im = im;
    model_beat(re, im);
  endtask

  task automatic gen_beat(input int m0, input int m1);
    logic [VW-1:0] re, im;
    int m, idx;
    for (int c = 0; c < CH; c++) begin
      m = (c == 0) ? m0 : m1;
      for (int l = 0; l < LANES; l++) begin
        re[(c*LANES+l)*LZ +: LZ] = LZ'(m + $urandom_range(31 - m));
        im[(c*LANES+l)*LZ +: LZ] = LZ'(m + $urandom_range(31 - m));
      end
      idx = $urandom_range(2*LANES - 1);
      if (idx < LANES) re[(c*LANES+idx)*LZ +: LZ] = LZ'(m);
      else             im[(c*LANES+idx-LANES)*LZ +: LZ] = LZ'(m);
    end
    drive_beat(re, im);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      in_valid = 1'b0; flush = 1'b0;
    end
  endtask

  task automatic do_flush();
    @(posedge clk); #2;
    in_valid = 1'b0; flush = 1'b1;
    m_cnt = 0;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due >= cyc + 1) sb.delete(i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check_eq({tag, "_min"}, {54'd0, out_min}, 64'd0);
    check_eq({tag, "_all"}, {59'd0, out_min_all}, 64'd0);
    check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] re, im;
    int len, gap;
    #1 rstn = 1'b0;
    #1 check_reset_outputs("rst0");
    idle(3);
    rstn = 1'b1;
    idle(2);

    // Single-beat block with explicit lane values
    blk_len = 7'd1;
    for (int l = 0; l < LANES; l++) begin
      re[l*LZ +: LZ] = (l == 3) ? 5'd2 : 5'd7;
      im[l*LZ +: LZ] = 5'd9;
      re[(LANES+l)*LZ +: LZ] = 5'd4;
      im[(LANES+l)*LZ +: LZ] = 5'd4;
    end
    drive_beat(re, im);
    idle(4);

    // Four-beat block, minimum lands on beat 3
    blk_len = 7'd4;
    gen_beat(6, 8); gen_beat(5, 8); gen_beat(1, 8); gen_beat(3, 7);
    idle(4);

    // Back-to-back two-beat blocks: second must not inherit the first's minimum
    blk_len = 7'd2;
    gen_beat(3, 3); gen_beat(3, 3); gen_beat(9, 9); gen_beat(9, 9);
    idle(4);

    // Gaps inside a block keep state; busy stays high
    blk_len = 7'd3;
    gen_beat(12, 14);
    idle(1); check_eq("busy_gap1", {63'd0, busy}, 64'd1);
    idle(1); check_eq("busy_gap2", {63'd0, busy}, 64'd1);
    gen_beat(8, 20);
    idle(1); check_eq("busy_gap3", {63'd0, busy}, 64'd1);
    gen_beat(15, 6);
    idle(1); check_eq("busy_tail", {63'd0, busy}, 64'd1);
    idle(1); check_eq("busy_done", {63'd0, busy}, 64'd0);
    idle(3);

    // Flush after two zero-minimum beats; those must not leak into the next block
    blk_len = 7'd4;
    gen_beat(0, 0); gen_beat(0, 0);
    do_flush();
    gen_beat(10, 12); gen_beat(11, 13); gen_beat(14, 12); gen_beat(10, 15);
    idle(4);

    // Flush while a last beat reaches the accumulator: no pulse
    blk_len = 7'd1;
    gen_beat(4, 4);
    do_flush();
    idle(4);

    // Oversized length clamps to MAX_BEATS
    blk_len = 7'd70;
    for (int i = 0; i < MAXB; i++) gen_beat($urandom_range(31, 2), $urandom_range(31, 2));
    idle(4);

    // Random lengths with random gaps
    for (int b = 0; b < 5; b++) begin
      len = $urandom_range(6, 1);
      blk_len = CW'(len);
      for (int i = 0; i < len; i++) begin
        gap = $urandom_range(2);
        if (gap != 0) idle(gap);
        gen_beat($urandom_range(31), $urandom_range(31));
      end
      idle(3);
    end

    // Asynchronous reset mid-block, then blk_len=0 behaves as 1
    blk_len = 7'd4;
    gen_beat(2, 2); gen_beat(3, 3);
    @(posedge clk); #2;
    in_valid = 1'b0;
    rstn = 1'b0;
    #1 check_reset_outputs("rst_mid");
    sb.delete(); m_cnt = 0; hold_min = '0; hold_all = '0;
    idle(2);
    rstn = 1'b1;
    blk_len = 7'd0;
    gen_beat(5, 5);
    idle(5);

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cbfp_min_accum.md
Name: cbfp_min_accum

Overview:
- Parametrised block-exponent detector for the CBFP stages of the FFT pipeline.
- Each valid beat carries, per channel, LANES real-part and LANES imaginary-part leading-zero counts.
- Reduces each channel's 2*LANES counts to a per-beat minimum, then accumulates a running minimum over a runtime-configurable block of beats.
- Emits one registered minimum per channel per completed block. This is the shift amount consumed by the downstream CBFP scaler. The default configuration covers the add and sub butterfly outputs.

Parameters:
- LZC_WIDTH, 5, bit width of each leading-zero count.
- LANES, 8, values per component (real or imag) per channel per beat. Power of two, >=1.
- CH, 2, number of independent channels.
- MAX_BEATS, 64, largest supported block length in beats.
- CNT_W, $clog2(MAX_BEATS+1), width of blk_len and of the internal beat counter.

Ports:
- clk, in, 1: clock.
- rstn, in, 1: reset.
- in_valid, in, 1: beat qualifier.
- in_re, in, CH*LANES*LZC_WIDTH: real-part counts. Channel c, lane l sits at slice [(c*LANES+l)*LZC_WIDTH +: LZC_WIDTH].
- in_im, in, CH*LANES*LZC_WIDTH: imaginary-part counts, same packing as in_re.
- blk_len, in, CNT_W: beats per block. Sampled on the first beat of each block.
- flush, in, 1: synchronous abort of the current partial block.
- out_valid, out, 1: one-cycle pulse, block result available.
- out_min, out, CH*LZC_WIDTH: per-channel block minimum. Channel c at [c*LZC_WIDTH +: LZC_WIDTH].
- out_min_all, out, LZC_WIDTH: minimum across all channels of the same block.
- busy, out, 1: a partial block or an in-flight beat exists.

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. On reset assertion out_valid=0, out_min=0, out_min_all=0, busy=0, beat counter=0, pipe valid=0, accumulators=all-ones.
- Stage 1 (tree): combinational min over 2*LANES values per channel, registered with a valid bit (s1_valid <= in_valid & ~flush). Unsigned compare; ties are irrelevant.
- Stage 2 (accumulate): on s1_valid:
  - If counter==0: acc[c] <= s1_min[c] (no merge with the stale value), and latch len_q from blk_len.
  - Otherwise: acc[c] <= min(acc[c], s1_min[c]).
  - Counter increments each beat.
  - When the beat is the last (counter == len_q-1): out_min[c] <= merged value, out_min_all <= min over c of the merged values, out_valid <= 1, counter <= 0.
- Latency: out_valid rises exactly 2 cycles after the in_valid cycle that carries a block's last beat. Throughput is one beat per cycle with no stalls.
- Back-to-back blocks: the beat after a last beat starts a new block with no bubble. blk_len may change between blocks and is ignored mid-block.
- blk_len==0 is treated as 1. blk_len>MAX_BEATS is clamped to MAX_BEATS.
- in_valid gaps inside a block are allowed. The counter and accumulators hold.
- out_min and out_min_all hold their last value between pulses. out_valid is 0 outside pulses.
- flush:
  - Clears the counter and s1_valid.
  - Discards the input beat of the same cycle and the beat already in stage 1.
  - No out_valid is produced for the aborted block.
  - If a last beat is in stage 2 during the flush cycle, flush wins and no pulse is produced.
  - out_min is untouched.
- busy = s1_valid | (counter != 0).

Test Plan:
- LANES=8, CH=2, blk_len=1. One beat: ch0 re all 7 except lane 3 = 2, im all 9; ch1 all 4 -> 2 cycles later out_valid=1 for exactly one cycle, out_min ch0=2, ch1=4, out_min_all=2.
- blk_len=4, beats with ch0 minima 6,5,1,3 and ch1 minima 8,8,8,7 -> single pulse 2 cycles after beat 4, ch0=1, ch1=7, out_min_all=1. No pulse on beats 1-3.
- Two back-to-back blk_len=2 blocks: block A minima (3,3) then block B minima (9,9) -> second pulse reports 9 (no carry-over from A), pulses 2 cycles apart.
- blk_len=3 with in_valid pattern 1,0,0,1,0,1 -> exactly one pulse, 2 cycles after the third valid. busy=1 throughout the gaps.
- flush asserted on the cycle after beat 2 of a blk_len=4 block, then 4 fresh beats with minimum 10 -> exactly one pulse, value 10. Earlier beats (minimum 0) do not leak in.
- rstn pulsed low mid-block, then blk_len=0 with one beat of minimum 5 -> immediate outputs 0 during reset; afterwards a pulse with out_min=5 two cycles after the beat.
